// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants, exception codes and opcode/funct encodings
package mips_pkg;

    typedef logic [4:0] exc_code_t;

    localparam logic [31:0] PC_BEGIN = 32'h0000_3000;

    localparam exc_code_t EXC_INT  = 5'd0;
    localparam exc_code_t EXC_ADEL = 5'd4;
    localparam exc_code_t EXC_ADES = 5'd5;
    localparam exc_code_t EXC_SYS  = 5'd8;
    localparam exc_code_t EXC_RI   = 5'd10;
    localparam exc_code_t EXC_OV   = 5'd12;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

endpackage

// File: rtl/if_id_reg_if.sv
// rtl/if_id_reg_if.sv - fetch/decode pipeline register bus with control and ID-side outputs
interface if_id_reg_if;
    import mips_pkg::*;

    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] if_pc;
    logic [31:0] if_ins;
    logic        if_erq;
    logic        ifu_we;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_ins;
    exc_code_t   id_exc;
    logic        id_bd;

    modport master (
        output stall, flush, flush_pc, if_pc, if_ins, if_erq,
        input  ifu_we, id_valid, id_pc, id_ins, id_exc, id_bd
    );

    modport slave (
        input  stall, flush, flush_pc, if_pc, if_ins, if_erq,
        output ifu_we, id_valid, id_pc, id_ins, id_exc, id_bd
    );
endinterface

// File: rtl/branch_predecode.sv
// rtl/branch_predecode.sv - flags branch/jump encodings whose successor sits in a delay slot
module branch_predecode
    import mips_pkg::*;
(
    input  logic [31:0] ins,
    output logic        is_br
);
    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = ins[31:26];
    assign funct  = ins[5:0];

    always_comb begin
        is_br = 1'b0;
        case (opcode)
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ,
            OP_REGIMM, OP_J, OP_JAL:          is_br = 1'b1;
            OP_SPECIAL:                       is_br = (funct == FN_JR) || (funct == FN_JALR);
            default:                          is_br = 1'b0;
        endcase
    end
endmodule

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - IF/ID pipeline register with AdEL tagging, delay-slot tracking and flush bubbles
module if_id_reg #(
    parameter logic [31:0]         PC_BEGIN = mips_pkg::PC_BEGIN,
    parameter mips_pkg::exc_code_t EXC_ADEL = mips_pkg::EXC_ADEL
) (
    input  logic        clk,
    input  logic        reset,
    if_id_reg_if.slave  bus
);
    logic                id_valid_q;
    logic [31:0]         id_pc_q;
    logic [31:0]         id_ins_q;
    mips_pkg::exc_code_t id_exc_q;
    logic                id_bd_q;
    logic                id_is_br;

    // Predecode looks at the word already in ID: its successor is the delay slot.
    branch_predecode u_predecode (
        .ins   (id_ins_q),
        .is_br (id_is_br)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid_q <= 1'b0;
            id_pc_q    <= PC_BEGIN;
            id_ins_q   <= 32'd0;
            id_exc_q   <= 5'd0;
            id_bd_q    <= 1'b0;
        end else if (bus.flush) begin
            // Bubble carries the redirect target so an interrupt on it reports a correct EPC.
            id_valid_q <= 1'b0;
            id_pc_q    <= bus.flush_pc;
            id_ins_q   <= 32'd0;
            id_exc_q   <= 5'd0;
            id_bd_q    <= 1'b0;
        end else if (!bus.stall) begin
            id_valid_q <= 1'b1;
            id_pc_q    <= bus.if_pc;
            id_ins_q   <= bus.if_erq ? 32'd0 : bus.if_ins;
            id_exc_q   <= bus.if_erq ? EXC_ADEL : 5'd0;
            id_bd_q    <= id_valid_q & id_is_br;
        end
    end

    // Redirect must load into the fetch PC even while the hazard unit stalls.
    assign bus.ifu_we   = ~bus.stall | bus.flush;
    assign bus.id_valid = id_valid_q;
    assign bus.id_pc    = id_pc_q;
    assign bus.id_ins   = id_ins_q;
    assign bus.id_exc   = id_exc_q;
    assign bus.id_bd    = id_bd_q;
endmodule

// File: tb/tb_if_id_reg.sv
// tb/tb_if_id_reg.sv - directed vector bench for if_id_reg
module tb_if_id_reg;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    if_id_reg_if bus ();

    if_id_reg dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] flush_pc;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        erq;
        logic        we;
        logic        v;
        logic [31:0] epc;
        logic [31:0] eins;
        logic [4:0]  exc;
        logic        bd;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rst, input logic stall, input logic flush,
                       input logic [31:0] flush_pc, input logic [31:0] pc,
                       input logic [31:0] ins, input logic erq, input logic we,
                       input logic v, input logic [31:0] epc, input logic [31:0] eins,
                       input logic [4:0] exc, input logic bd);
        vec_t t;
        t.rst = rst; t.stall = stall; t.flush = flush; t.flush_pc = flush_pc;
        t.pc = pc; t.ins = ins; t.erq = erq; t.we = we; t.v = v;
        t.epc = epc; t.eins = eins; t.exc = exc; t.bd = bd;
        vq.push_back(t);
    endtask

    task automatic check(input string name, input int idx,
                         input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic stall, input logic flush,
                         input logic [31:0] flush_pc, input logic [31:0] pc,
                         input logic [31:0] ins, input logic erq);
        reset        = rst;
        bus.stall    = stall;
        bus.flush    = flush;
        bus.flush_pc = flush_pc;
        bus.if_pc    = pc;
        bus.if_ins   = ins;
        bus.if_erq   = erq;
    endtask

    task automatic check_id(input int idx, input logic v, input logic [31:0] epc,
                            input logic [31:0] eins, input logic [4:0] exc, input logic bd);
        check("id_valid", idx, {31'd0, bus.id_valid}, {31'd0, v});
        check("id_pc",    idx, bus.id_pc, epc);
        check("id_ins",   idx, bus.id_ins, eins);
        check("id_exc",   idx, {27'd0, bus.id_exc}, {27'd0, exc});
        check("id_bd",    idx, {31'd0, bus.id_bd}, {31'd0, bd});
    endtask

    initial begin
        //   rst stl fl flush_pc        pc             ins            erq we v  epc            eins           exc bd
        add(1, 0, 0, 32'h0,          32'h0,          32'h0,          0, 1, 0, 32'h3000,     32'h0,         0, 0);
        add(0, 0, 0, 32'h0,          32'h3000,       32'h10000003,   0, 1, 1, 32'h3000,     32'h10000003,  0, 0);
        add(0, 0, 0, 32'h0,          32'h3004,       32'h0,          0, 1, 1, 32'h3004,     32'h0,         0, 1);
        add(0, 0, 0, 32'h0,          32'h3008,       32'h0,          0, 1, 1, 32'h3008,     32'h0,         0, 0);
        add(0, 0, 0, 32'h0,          32'h300c,       32'h0c000100,   0, 1, 1, 32'h300c,     32'h0c000100,  0, 0);
        add(0, 0, 0, 32'h0,          32'h3010,       32'h0,          0, 1, 1, 32'h3010,     32'h0,         0, 1);
        add(0, 1, 0, 32'h0,          32'h3014,       32'h00001234,   0, 0, 1, 32'h3010,     32'h0,         0, 1);
        add(0, 1, 0, 32'h0,          32'h3014,       32'h00001234,   0, 0, 1, 32'h3010,     32'h0,         0, 1);
        add(0, 1, 0, 32'h0,          32'h3014,       32'h00001234,   0, 0, 1, 32'h3010,     32'h0,         0, 1);
        add(0, 0, 0, 32'h0,          32'h3014,       32'h03e00008,   0, 1, 1, 32'h3014,     32'h03e00008,  0, 0);
        add(0, 1, 1, 32'h4180,       32'h3018,       32'h0,          0, 1, 0, 32'h4180,     32'h0,         0, 0);
        add(0, 0, 0, 32'h0,          32'h4180,       32'h0c000000,   0, 1, 1, 32'h4180,     32'h0c000000,  0, 0);
        add(0, 0, 0, 32'h0,          32'h3001,       32'h0,          1, 1, 1, 32'h3001,     32'h0,         4, 1);
        add(0, 0, 0, 32'h0,          32'h3008,       32'h0,          0, 1, 1, 32'h3008,     32'h0,         0, 0);
        add(0, 0, 0, 32'h0,          32'h300c,       32'h42000018,   0, 1, 1, 32'h300c,     32'h42000018,  0, 0);
        add(0, 0, 0, 32'h0,          32'h3010,       32'h0000000c,   0, 1, 1, 32'h3010,     32'h0000000c,  0, 0);
        add(0, 0, 0, 32'h0,          32'h3014,       32'h04010002,   0, 1, 1, 32'h3014,     32'h04010002,  0, 0);
        add(0, 0, 0, 32'h0,          32'h3018,       32'h0,          0, 1, 1, 32'h3018,     32'h0,         0, 1);
        add(0, 1, 0, 32'h0,          32'h301c,       32'h0,          0, 0, 1, 32'h3018,     32'h0,         0, 1);
        add(1, 1, 0, 32'h0,          32'h301c,       32'h0,          0, 0, 0, 32'h3000,     32'h0,         0, 0);
        add(0, 1, 0, 32'h0,          32'h301c,       32'h0,          0, 0, 0, 32'h3000,     32'h0,         0, 0);
        add(0, 0, 1, 32'h80000180,   32'h301c,       32'h0,          0, 1, 0, 32'h80000180, 32'h0,         0, 0);
        add(1, 0, 1, 32'h80000180,   32'h301c,       32'h0,          0, 1, 0, 32'h3000,     32'h0,         0, 0);
        add(0, 0, 0, 32'h0,          32'h3000,       32'h14000001,   0, 1, 1, 32'h3000,     32'h14000001,  0, 0);
        add(0, 0, 0, 32'h0,          32'h3004,       32'h0000f809,   0, 1, 1, 32'h3004,     32'h0000f809,  0, 1);
        add(0, 0, 0, 32'h0,          32'h3008,       32'h18000001,   0, 1, 1, 32'h3008,     32'h18000001,  0, 1);
        add(0, 0, 0, 32'h0,          32'h300c,       32'h1c000001,   0, 1, 1, 32'h300c,     32'h1c000001,  0, 1);
        add(0, 0, 0, 32'h0,          32'h3010,       32'h08000c00,   0, 1, 1, 32'h3010,     32'h08000c00,  0, 1);
        add(0, 0, 0, 32'h0,          32'h3014,       32'h00000021,   0, 1, 1, 32'h3014,     32'h00000021,  0, 1);
        add(0, 0, 0, 32'h0,          32'h3018,       32'h8c000000,   0, 1, 1, 32'h3018,     32'h8c000000,  0, 0);
        add(0, 0, 0, 32'h0,          32'h301c,       32'h0,          0, 1, 1, 32'h301c,     32'h0,         0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i].rst, vq[i].stall, vq[i].flush, vq[i].flush_pc,
                  vq[i].pc, vq[i].ins, vq[i].erq);
            #1;
            check("ifu_we", i, {31'd0, bus.ifu_we}, {31'd0, vq[i].we});
            @(posedge clk);
            #1;
            check_id(i, vq[i].v, vq[i].epc, vq[i].eins, vq[i].exc, vq[i].bd);
        end

        // Branch in ID flushed away: the bubble and its successor never carry BD.
        drive(0, 0, 0, 32'h0, 32'h5000, 32'h10000003, 0);
        @(posedge clk); #1;
        check_id(100, 1, 32'h5000, 32'h10000003, 0, 0);
        drive(0, 0, 1, 32'h4180, 32'h5004, 32'h0, 0);
        @(posedge clk); #1;
        check_id(101, 0, 32'h4180, 32'h0, 0, 0);
        drive(0, 0, 0, 32'h0, 32'h4180, 32'h0, 0);
        @(posedge clk); #1;
        check_id(102, 1, 32'h4180, 32'h0, 0, 0);

        // Faulting fetch after a stall released on a branch still tags AdEL with BD.
        drive(0, 0, 0, 32'h0, 32'h4184, 32'h0c000000, 0);
        @(posedge clk); #1;
        drive(0, 1, 0, 32'h0, 32'h4189, 32'h0, 1);
        @(posedge clk); #1;
        check_id(103, 1, 32'h4184, 32'h0c000000, 0, 0);
        drive(0, 0, 0, 32'h0, 32'h4189, 32'h0, 1);
        @(posedge clk); #1;
        check_id(104, 1, 32'h4189, 32'h0, 4, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/if_id_reg.md
# if_id_reg

Pipeline register between the instruction fetch unit and decode. It captures the fetched PC and instruction word, and converts a fetch-address error into an AdEL exception tag. It tracks the branch-delay-slot (BD) flag for CP0 and inserts bubbles on flush. It also drives the fetch unit's PC write enable, so the hazard unit and the exception controller steer fetch through this one block.

## Interface
Parameters:
- PC_BEGIN, 'h3000, PC value held in id_pc after reset.
- EXC_ADEL, 5'd4, ExcCode for an instruction-fetch address error.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- stall  in  1  from hazard unit; hold the ID stage and the fetch PC.
- flush  in  1  from exception/eret logic; squash the fetched instruction, insert a bubble.
- flush_pc  in  32  redirect target (handler entry or EPC); the bubble carries it.
- if_pc  in  32  current fetch PC.
- if_ins  in  32  fetched word; 0 when if_erq.
- if_erq  in  1  fetch address error (misaligned or out of range).
- ifu_we  out  1  PC write enable to the fetch unit.
- id_valid  out  1  ID holds a real instruction (not a bubble).
- id_pc  out  32  PC of the ID instruction.
- id_ins  out  32  instruction word; 0 for bubbles and faulting fetches.
- id_exc  out  5  ExcCode; 0 means none.
- id_bd  out  1  ID instruction sits in a branch delay slot.

## Operation
- Priority, per cycle: reset > flush > stall > advance.
- Reset values:
  - id_valid 0, id_pc PC_BEGIN, id_ins 0, id_exc 0, id_bd 0.
  - ifu_we is combinational, so during reset it still follows ~stall | flush.
- Advance (no reset, no flush, no stall):
  - id_valid <= 1; id_pc <= if_pc.
  - id_ins <= if_erq ? 0 : if_ins.
  - id_exc <= if_erq ? EXC_ADEL : 0.
  - id_bd <= id_valid & br(id_ins), where br() is the predecode of the word currently in ID.
- Stall: every ID register holds its value.
- Flush: id_valid 0, id_ins 0, id_exc 0, id_bd 0, id_pc <= flush_pc. An interrupt taken on the bubble therefore reports the correct EPC.
- Flush overrides stall in the same cycle.
- ifu_we = ~stall | flush. The fetch unit must load the redirect even while the hazard unit asserts stall.
- br() is true for these encodings, false for everything else (including eret and syscall):
  - opcode 000100 beq, 000101 bne, 000110 blez, 000111 bgtz.
  - opcode 000001 REGIMM (bltz/bgez).
  - opcode 000010 j, 000011 jal.
  - opcode 000000 with funct 001000 jr, 001001 jalr.
- A faulting fetch that follows a branch gets id_exc = EXC_ADEL and id_bd = 1. CP0 must see both.
- A bubble never sets BD on its successor, because id_valid = 0 masks br().

## Timing
- Latency: one cycle from IF inputs to ID outputs.
- All ID outputs are registered. ifu_we is the only combinational output.
- A stall of N cycles holds ID for N cycles. The first non-stalled edge captures if_pc, which was also held because ifu_we was 0.
- Flush takes effect at the next edge. The instruction that follows it arrives from flush_pc one edge later, with id_bd = 0.
- Reset mid-stall or mid-flush: reset values win at that edge. Stall and flush resume being honoured on the following edge.

## Structure
- Shared package mips_pkg holds:
  - PC_BEGIN, EXC_ADEL and the other ExcCode constants;
  - the opcode and funct constants used by br();
  - a 5-bit exc_code_t.
- Sub-module branch_predecode: combinational, 32-bit instruction in, 1-bit is_br out. Decode reuses it for its own delay-slot logic.

## Test plan
- Reset with stall = 0: id_valid 0, id_pc 'h3000, id_ins 0, id_exc 0, id_bd 0, ifu_we 1.
- Feed if_pc 'h3000/ins 'h10000003 (beq), then 'h3004/ins 'h00000000 on consecutive edges:
  - second ID entry has id_bd 1;
  - a third entry 'h3008 has id_bd 0.
- Assert stall for 3 cycles with id_pc 'h3010: ID outputs unchanged for 3 edges, ifu_we 0 throughout.
- Assert stall and flush together with flush_pc 'h4180: ifu_we 1; next edge gives id_valid 0, id_ins 0, id_pc 'h4180.
- if_erq 1 with if_pc 'h3001 following a jal in ID: id_ins 0, id_exc 4, id_bd 1, id_valid 1.
- Assert reset during a stall with valid ID contents: the next edge gives reset values regardless of stall.
